cpri_prb_pack: RTL and testbench

Packs the bursty 32-bit compressed-PRB stream from the PUSCH combiner into fixed-length 64-bit CPRI blocks. Each block is one header word plus padded payload. Blocks are emitted as gap-free bursts marked by a start-of-packet, on the `o_cpri_sop` / `o_cpri_wdata` interface that feeds the CPRI TX generator's write side. A two-bank ping-pong buffer decouples irregular input from contiguous output.

---
 rtl/cpri_prb_pack.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_cpri_prb_pack.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpri_prb_pack.sv
// cpri_prb_pack: packs a bursty 32-bit compressed-PRB stream into fixed-length
// 64-bit CPRI blocks (one header word + BLK_WORDS-1 payload words) through a
// two-bank ping-pong buffer, emitting each block as a gap-free burst.
// Optional feature macro: CPRI_PACK_CHK_EN -- when defined, header[31:0]
// carries the XOR of all accepted payload words of the block.
module cpri_prb_pack #(
  parameter int BLK_WORDS = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vld,
  input  logic        i_sof,
  input  logic        i_eof,
  input  logic [31:0] i_data,
  input  logic [7:0]  i_slot_idx,
  input  logic [3:0]  i_sym_idx,
  output logic        o_cpri_sop,
  output logic        o_cpri_vld,
  output logic [63:0] o_cpri_wdata,
  output logic        o_ovf,
  output logic        o_err
);

  localparam int         PAY      = BLK_WORDS - 1;
  localparam int         DEPTH    = 2 * PAY;
  localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] CAP      = 8'(2 * PAY);
  localparam logic [6:0] PAY_LAST = 7'(PAY);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_PAY, R_GAP} r_state_e;

  // Write side
  w_state_e    w_state_q, w_state_d;
  logic        w_bank_q;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic [31:0] w_hold_q, w_hold_d;
  logic        w_trunc_q, w_trunc_d;
  logic [7:0]  w_slot_q, w_slot_d;
  logic [3:0]  w_sym_q, w_sym_d;
  logic        commit;
  logic        ovf_d, err_d;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [IW-1:0] w_idx;

  // Per-bank header registers and full flags
  logic [1:0]  full_q, set_full, clr_full;
  logic [7:0]  b_slot_q [2];
  logic [3:0]  b_sym_q  [2];
  logic [7:0]  b_cnt_q  [2];
  logic [31:0] hdr_chk;

  // Payload storage, bank b occupies entries [b*PAY, b*PAY+PAY-1]
  logic [63:0] mem_q [DEPTH];

  // Read side
  r_state_e    r_state_q, r_state_d;
  logic        r_bank_q, r_bank_d;
  logic [6:0]  r_addr_q, r_addr_d;
  logic        sop_d, vld_d, sel_hdr, sel_ram;
  logic [8:0]  wr_words;
  logic        rd_ok;
  logic [IW-1:0] r_idx;
  logic [63:0] header;

  // Registered outputs
  logic        sop_q, vld_q, ovf_q, err_q;
  logic [63:0] wdata_q;

  assign o_cpri_sop   = sop_q;
  assign o_cpri_vld   = vld_q;
  assign o_cpri_wdata = wdata_q;
  assign o_ovf        = ovf_q;
  assign o_err        = err_q;

  // Write FSM: framing, packing of 32-bit words into 64-bit payload words, truncation
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_hold_d  = w_hold_q;
    w_trunc_d = w_trunc_q;
    w_slot_d  = w_slot_q;
    w_sym_d   = w_sym_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    commit    = 1'b0;
    ovf_d     = 1'b0;
    err_d     = 1'b0;
    if (i_vld) begin
      if (i_sof) begin
        // A sof outside W_IDLE abandons (W_FILL) or ends (W_DROP) the current block.
        if (w_state_q != W_IDLE) err_d = 1'b1;
        if (full_q[w_bank_q]) begin
          ovf_d     = 1'b1;
          w_state_d = i_eof ? W_IDLE : W_DROP;
        end else begin
          w_slot_d  = i_slot_idx;
          w_sym_d   = i_sym_idx;
          w_cnt_d   = 8'd1;
          w_trunc_d = 1'b0;
          w_hold_d  = i_data;
          if (i_eof) begin
            mem_we    = 1'b1;
            mem_wdata = {i_data, 32'h0};
            commit    = 1'b1;
            w_state_d = W_IDLE;
          end else begin
            w_state_d = W_FILL;
          end
        end
      end else begin
        case (w_state_q)
          W_IDLE: err_d = 1'b1;
          W_FILL: begin
            if (w_cnt_q == CAP) begin
              ovf_d     = ~w_trunc_q;
              w_trunc_d = 1'b1;
            end else begin
              w_cnt_d  = w_cnt_q + 8'd1;
              mem_addr = w_cnt_q[7:1];
              if (w_cnt_q[0]) begin
                mem_we    = 1'b1;
                mem_wdata = {w_hold_q, i_data};
              end else begin
                w_hold_d = i_data;
                if (i_eof) begin
                  mem_we    = 1'b1;
                  mem_wdata = {i_data, 32'h0};
                end
              end
            end
            if (i_eof) begin
              commit    = 1'b1;
              w_state_d = W_IDLE;
            end
          end
          W_DROP: if (i_eof) w_state_d = W_IDLE;
          default: w_state_d = W_IDLE;
        endcase
      end
    end
  end

  // Full flag set request for the bank being committed
  always_comb begin
    set_full           = 2'b00;
    set_full[w_bank_q] = commit;
  end

  assign w_idx = IW'((w_bank_q ? PAY : 0) + int'(mem_addr));

  // Write-side state, per-bank header capture and full flags
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      w_state_q <= W_IDLE;
      w_bank_q  <= 1'b0;
      w_cnt_q   <= '0;
      w_hold_q  <= '0;
      w_trunc_q <= 1'b0;
      w_slot_q  <= '0;
      w_sym_q   <= '0;
      full_q    <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        b_slot_q[b] <= '0;
        b_sym_q[b]  <= '0;
        b_cnt_q[b]  <= '0;
      end
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_hold_q  <= w_hold_d;
      w_trunc_q <= w_trunc_d;
      w_slot_q  <= w_slot_d;
      w_sym_q   <= w_sym_d;
      full_q    <= (full_q | set_full) & ~clr_full;
      if (commit) begin
        b_slot_q[w_bank_q] <= w_slot_d;
        b_sym_q[w_bank_q]  <= w_sym_d;
        b_cnt_q[w_bank_q]  <= w_cnt_d;
        w_bank_q           <= ~w_bank_q;
      end
    end
  end

  // Payload RAM write port
  always_ff @(posedge clk) begin
    // NOTE: the RAM is not reset; the per-bank word count masks stale entries on read.
    if (mem_we) mem_q[w_idx] <= mem_wdata;
  end

`ifdef CPRI_PACK_CHK_EN
  logic [31:0] w_chk_q, w_chk_d;
  logic [31:0] b_chk_q [2];

  // Running XOR of accepted words; restarts on every accepted sof
  always_comb begin
    w_chk_d = w_chk_q;
    if (i_vld && i_sof && !full_q[w_bank_q])
      w_chk_d = i_data;
    else if (i_vld && !i_sof && (w_state_q == W_FILL) && (w_cnt_q != CAP))
      w_chk_d = w_chk_q ^ i_data;
  end

  // Checksum accumulator and per-bank capture at commit
  always_ff @(posedge clk) begin
    if (rst) begin
      w_chk_q    <= '0;
      b_chk_q[0] <= '0;
      b_chk_q[1] <= '0;
    end else begin
      w_chk_q <= w_chk_d;
      if (commit) b_chk_q[w_bank_q] <= w_chk_d;
    end
  end

  assign hdr_chk = b_chk_q[r_bank_q];
`else
  assign hdr_chk = 32'h0;
`endif

  assign header   = {8'hA5, b_slot_q[r_bank_q], b_sym_q[r_bank_q], 4'h0,
                     b_cnt_q[r_bank_q], hdr_chk};
  assign wr_words = ({1'b0, b_cnt_q[r_bank_q]} + 9'd1) >> 1;
  assign rd_ok    = ({2'b00, r_addr_q} < wr_words);
  assign r_idx    = IW'((r_bank_q ? PAY : 0) + int'(r_addr_q));

  // Read FSM: header, payload read one cycle ahead, then a one-cycle gap
  always_comb begin
    r_state_d = r_state_q;
    r_bank_d  = r_bank_q;
    r_addr_d  = r_addr_q;
    clr_full  = 2'b00;
    sop_d     = 1'b0;
    vld_d     = 1'b0;
    sel_hdr   = 1'b0;
    sel_ram   = 1'b0;
    case (r_state_q)
      R_IDLE: if (full_q[r_bank_q]) begin
        r_state_d = R_HDR;
        sop_d     = 1'b1;
        vld_d     = 1'b1;
        sel_hdr   = 1'b1;
        r_addr_d  = '0;
      end
      R_HDR: begin
        r_state_d = R_PAY;
        vld_d     = 1'b1;
        sel_ram   = 1'b1;
        r_addr_d  = r_addr_q + 7'd1;
      end
      R_PAY: begin
        if (r_addr_q == PAY_LAST) begin
          clr_full[r_bank_q] = 1'b1;
          r_bank_d           = ~r_bank_q;
          r_state_d          = R_GAP;
        end else begin
          vld_d    = 1'b1;
          sel_ram  = 1'b1;
          r_addr_d = r_addr_q + 7'd1;
        end
      end
      R_GAP:   r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read-side state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_bank_q  <= 1'b0;
      r_addr_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_bank_q  <= r_bank_d;
      r_addr_q  <= r_addr_d;
    end
  end

  // Output registers; the RAM read lands directly in the data output register
  always_ff @(posedge clk) begin
    if (rst) begin
      sop_q   <= 1'b0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      sop_q <= sop_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      if (sel_hdr)              wdata_q <= header;
      else if (sel_ram && rd_ok) wdata_q <= mem_q[r_idx];
      else                      wdata_q <= '0;
    end
  end

endmodule

// File: tb/tb_cpri_prb_pack.sv
// Directed testbench for cpri_prb_pack with BLK_WORDS=4 (3 payload words, CAP=6).
module tb_cpri_prb_pack;
  localparam int BW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vld = 1'b0, i_sof = 1'b0, i_eof = 1'b0;
  logic [31:0] i_data = '0;
  logic [7:0]  i_slot_idx = '0;
  logic [3:0]  i_sym_idx = '0;
  logic        o_cpri_sop, o_cpri_vld, o_ovf, o_err;
  logic [63:0] o_cpri_wdata;

  int checks = 0, failures = 0;
  int cyc = 0, ovf_cnt = 0, err_cnt = 0, stray = 0, eof_cyc = 0;
  logic [63:0] q_data[$];
  logic        q_sop[$];
  int          q_cyc[$];

  cpri_prb_pack #(.BLK_WORDS(BW)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_sof(i_sof), .i_eof(i_eof),
    .i_data(i_data), .i_slot_idx(i_slot_idx), .i_sym_idx(i_sym_idx),
    .o_cpri_sop(o_cpri_sop), .o_cpri_vld(o_cpri_vld), .o_cpri_wdata(o_cpri_wdata),
    .o_ovf(o_ovf), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Output log sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_cpri_vld) begin
      q_data.push_back(o_cpri_wdata);
      q_sop.push_back(o_cpri_sop);
      q_cyc.push_back(cyc);
    end else if (o_cpri_wdata !== 64'h0 || o_cpri_sop !== 1'b0) begin
      stray = stray + 1;
    end
    if (o_ovf) ovf_cnt = ovf_cnt + 1;
    if (o_err) err_cnt = err_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] hdr(input logic [7:0] sl, input logic [3:0] sy,
                                      input logic [11:0] cnt, input logic [31:0] chk);
    logic [31:0] c;
    c = chk;
`ifndef CPRI_PACK_CHK_EN
    c = 32'h0;
`endif
    return {8'hA5, sl, sy, cnt, c};
  endfunction

  task automatic send(input logic sof, input logic eof, input logic [31:0] d,
                      input logic [7:0] sl, input logic [3:0] sy);
    i_vld = 1'b1; i_sof = sof; i_eof = eof; i_data = d;
    i_slot_idx = sl; i_sym_idx = sy;
    if (eof) eof_cyc = cyc + 1;
    @(posedge clk); #1;
    i_vld = 1'b0; i_sof = 1'b0; i_eof = 1'b0; i_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_data.delete(); q_sop.delete(); q_cyc.delete();
    ovf_cnt = 0; err_cnt = 0; stray = 0;
  endtask

  task automatic wait_words(input int n, input string name);
    int t = 0;
    while (q_data.size() < n && t < 60) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q_data.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: got %0d words, need %0d", name, q_data.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checks++;
    if ({o_cpri_sop, o_cpri_vld, o_ovf, o_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000", {o_cpri_sop, o_cpri_vld, o_ovf, o_err});
    end
    checks++;
    if (o_cpri_wdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_wdata: got %h want 0", o_cpri_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    checks++;
    if ({o_cpri_sop, o_cpri_vld, o_ovf, o_err} !== 4'b0 || o_cpri_wdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_idle: outputs not quiet after release");
    end
  endtask

  task automatic test_basic();
    logic [63:0] exp[4];
    exp[0] = hdr(8'h12, 4'h3, 12'd3, 32'h0);
    exp[1] = 64'h0000_0001_0000_0002;
    exp[2] = 64'h0000_0003_0000_0000;
    exp[3] = 64'h0;
    clear_log();
    send(1, 0, 32'd1, 8'h12, 4'h3);
    send(0, 0, 32'd2, 8'h12, 4'h3);
    send(0, 1, 32'd3, 8'h12, 4'h3);
    wait_words(4, "basic");
    idle(6);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== exp[i]) begin
        failures++;
        $display("FAIL basic_word%0d: got %h want %h", i, q_data[i], exp[i]);
      end
    end
    checks++;
    if (q_sop[0] !== 1'b1 || q_sop[1] !== 1'b0 || q_sop[2] !== 1'b0 || q_sop[3] !== 1'b0) begin
      failures++;
      $display("FAIL basic_sop: got %b%b%b%b want 1000", q_sop[0], q_sop[1], q_sop[2], q_sop[3]);
    end
    checks++;
    if (q_cyc[0] != eof_cyc + 2) begin
      failures++;
      $display("FAIL basic_latency: sop at %0d want %0d", q_cyc[0], eof_cyc + 2);
    end
    checks++;
    if (q_data.size() != 4 || q_cyc[3] != q_cyc[0] + 3 || stray != 0) begin
      failures++;
      $display("FAIL basic_burst: words %0d span %0d stray %0d want 4 3 0",
               q_data.size(), q_cyc[3] - q_cyc[0], stray);
    end
  endtask

  task automatic test_truncate();
    logic [63:0] exp[4];
    exp[0] = hdr(8'h56, 4'h7, 12'd6, 32'h7);
    exp[1] = 64'h0000_0001_0000_0002;
    exp[2] = 64'h0000_0003_0000_0004;
    exp[3] = 64'h0000_0005_0000_0006;
    clear_log();
    for (int i = 1; i <= 8; i++)
      send(i == 1, i == 8, 32'(i), 8'h56, 4'h7);
    wait_words(4, "trunc");
    idle(6);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== exp[i]) begin
        failures++;
        $display("FAIL trunc_word%0d: got %h want %h", i, q_data[i], exp[i]);
      end
    end
    checks++;
    if (ovf_cnt != 1 || err_cnt != 0 || q_data.size() != 4) begin
      failures++;
      $display("FAIL trunc_flags: ovf %0d err %0d words %0d want 1 0 4",
               ovf_cnt, err_cnt, q_data.size());
    end
  endtask

  task automatic test_single();
    logic [63:0] exp[4];
    exp[0] = hdr(8'h34, 4'h5, 12'd1, 32'hDEAD_BEEF);
    exp[1] = 64'hDEAD_BEEF_0000_0000;
    exp[2] = 64'h0;
    exp[3] = 64'h0;
    clear_log();
    send(1, 1, 32'hDEAD_BEEF, 8'h34, 4'h5);
    wait_words(4, "single");
    idle(6);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== exp[i]) begin
        failures++;
        $display("FAIL single_word%0d: got %h want %h", i, q_data[i], exp[i]);
      end
    end
    checks++;
    if (q_data.size() != BW || q_cyc[BW-1] != q_cyc[0] + BW - 1 || q_cyc[0] != eof_cyc + 2) begin
      failures++;
      $display("FAIL single_vld: words %0d span %0d want %0d %0d",
               q_data.size(), q_cyc[BW-1] - q_cyc[0], BW, BW - 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp[8];
    exp[0] = hdr(8'h01, 4'h1, 12'd2, 32'h1);
    exp[1] = 64'h0000_0010_0000_0011;
    exp[2] = 64'h0;
    exp[3] = 64'h0;
    exp[4] = hdr(8'h02, 4'h2, 12'd2, 32'h1);
    exp[5] = 64'h0000_0020_0000_0021;
    exp[6] = 64'h0;
    exp[7] = 64'h0;
    clear_log();
    send(1, 0, 32'h10, 8'h01, 4'h1);
    send(0, 1, 32'h11, 8'h01, 4'h1);
    send(1, 0, 32'h20, 8'h02, 4'h2);
    send(0, 1, 32'h21, 8'h02, 4'h2);
    send(1, 0, 32'h30, 8'h03, 4'h3);
    send(0, 1, 32'h31, 8'h03, 4'h3);
    wait_words(8, "b2b");
    idle(10);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_data[i] !== exp[i]) begin
        failures++;
        $display("FAIL b2b_word%0d: got %h want %h", i, q_data[i], exp[i]);
      end
    end
    checks++;
    if (q_cyc[4] != q_cyc[3] + 3 || q_sop[4] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: next sop %0d cycles after last word, want 3", q_cyc[4] - q_cyc[3]);
    end
    checks++;
    if (ovf_cnt != 1 || err_cnt != 0 || q_data.size() != 8) begin
      failures++;
      $display("FAIL b2b_drop: ovf %0d err %0d words %0d want 1 0 8",
               ovf_cnt, err_cnt, q_data.size());
    end
  endtask

  task automatic test_framing();
    logic [63:0] exp[4];
    exp[0] = hdr(8'h77, 4'h9, 12'd3, 32'h0);
    exp[1] = 64'h0000_0100_0000_0200;
    exp[2] = 64'h0000_0300_0000_0000;
    exp[3] = 64'h0;
    clear_log();
    send(0, 0, 32'hBAD, 8'h66, 4'h1);
    idle(1);
    send(1, 0, 32'hAA, 8'h66, 4'h1);
    send(0, 0, 32'hBB, 8'h66, 4'h1);
    send(1, 0, 32'h100, 8'h77, 4'h9);
    send(0, 0, 32'h200, 8'h77, 4'h9);
    send(0, 1, 32'h300, 8'h77, 4'h9);
    wait_words(4, "frame");
    idle(8);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_data[i] !== exp[i]) begin
        failures++;
        $display("FAIL frame_word%0d: got %h want %h", i, q_data[i], exp[i]);
      end
    end
    checks++;
    if (err_cnt != 2 || ovf_cnt != 0 || q_data.size() != 4) begin
      failures++;
      $display("FAIL frame_flags: err %0d ovf %0d words %0d want 2 0 4",
               err_cnt, ovf_cnt, q_data.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    send(1, 0, 32'h5, 8'h9A, 4'hC);
    send(0, 1, 32'h6, 8'h9A, 4'hC);
    wait_words(2, "rstmid");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_cpri_sop, o_cpri_vld, o_ovf, o_err} !== 4'b0 || o_cpri_wdata !== 64'h0) begin
      failures++;
      $display("FAIL rstmid_outputs: sop %b vld %b ovf %b err %b wdata %h want all 0",
               o_cpri_sop, o_cpri_vld, o_ovf, o_err, o_cpri_wdata);
    end
    @(posedge clk); #1;
    clear_log();
    idle(15);
    checks++;
    if (q_data.size() != 0 || stray != 0) begin
      failures++;
      $display("FAIL rstmid_quiet: words %0d stray %0d want 0 0", q_data.size(), stray);
    end
    send(1, 1, 32'hCAFE_0001, 8'h01, 4'h2);
    wait_words(4, "rstmid_new");
    idle(6);
    checks++;
    if (q_data[0] !== hdr(8'h01, 4'h2, 12'd1, 32'hCAFE_0001) ||
        q_data[1] !== 64'hCAFE_0001_0000_0000 || q_data[2] !== 64'h0 || q_data[3] !== 64'h0) begin
      failures++;
      $display("FAIL rstmid_new: got %h %h %h %h", q_data[0], q_data[1], q_data[2], q_data[3]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncate();
    test_single();
    test_back_to_back();
    test_framing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
